// File: rtl/clk_en_pkg.sv
// +------------------------------------------------------------------+
// | clk_en_pkg : shared types and defaults for the clock-enable       |
// |              scheduler                                            |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package clk_en_pkg;

    localparam int CNT_W_DEF = 19;

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2
    } sched_state_t;

    // Reset divisor: half the counter range minus one.
    function automatic int unsigned rst_div_default(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_en_sched_if.sv
// +------------------------------------------------------------------+
// | clk_en_sched_if : control, configuration and strobe bundle of     |
// |                   the clock-enable scheduler                      |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface clk_en_sched_if
    import clk_en_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              run_en;
    logic              step_req;
    logic              step_ack;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [N_CH-1:0]   tick;
    logic [N_CH-1:0]   phase;
    logic              busy;

    modport master (
        output run_en, step_req, cfg_we, cfg_ch, cfg_div,
        input  step_ack, tick, phase, busy
    );

    modport slave (
        input  run_en, step_req, cfg_we, cfg_ch, cfg_div,
        output step_ack, tick, phase, busy
    );

endinterface

`default_nettype wire

// File: rtl/clk_en_chan.sv
// +------------------------------------------------------------------+
// | clk_en_chan : one divider channel (counter, divisor, pending      |
// |               divisor, tick strobe and phase square wave)         |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(rst_div_default(CNT_W))
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             advance,
    input  wire logic             stopped,
    input  wire logic             cfg_we,
    input  wire logic [CNT_W-1:0] cfg_div,
    output logic                  tick,
    output logic                  phase,
    output logic                  wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;

    assign wrap = advance && (cnt_q == div_q);

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        tick_d     = 1'b0;
        phase_d    = phase_q;

        if (wrap) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            phase_d = ~phase_q;
            if (pend_vld_q) begin
                div_d      = pend_q;
                pend_vld_d = 1'b0;
            end
        end else if (advance) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A write coinciding with the wrap supersedes whatever was pending.
        if (cfg_we) begin
            if (stopped) begin
                div_d = cfg_div;
                cnt_d = '0;
            end else if (wrap) begin
                div_d      = cfg_div;
                pend_vld_d = 1'b0;
            end else begin
                pend_d     = cfg_div;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= RST_DIV;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            tick_q     <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
            phase_q    <= phase_d;
        end
    end

    assign tick  = tick_q;
    assign phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/clk_en_sched.sv
// +------------------------------------------------------------------+
// | clk_en_sched : run/stop/single-step controller driving N_CH       |
// |                clock-enable divider channels                      |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module clk_en_sched
    import clk_en_pkg::*;
#(
    parameter int               N_CH    = 2,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(rst_div_default(CNT_W))
) (
    input  wire logic      CLK,
    input  wire logic      RST_N,
    clk_en_sched_if.slave  sif
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    sched_state_t state_q, state_d;
    logic         step_ack_q, step_ack_d;
    logic         busy_q, busy_d;

    logic         w_advance;
    logic         w_stopped;
    logic [N_CH-1:0] w_tick;
    logic [N_CH-1:0] w_phase;
    logic [N_CH-1:0] w_wrap;
    logic         w_unused_wrap;

    assign w_advance = (state_q == RUNNING) || (state_q == STEPPING);
    assign w_stopped = (state_q == STOPPED);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic w_we;
        assign w_we = sif.cfg_we && (sif.cfg_ch == CH_W'(i));

        clk_en_chan #(
            .CNT_W   (CNT_W),
            .RST_DIV (RST_DIV)
        ) u_chan (
            .clk     (CLK),
            .rst_n   (RST_N),
            .advance (w_advance),
            .stopped (w_stopped),
            .cfg_we  (w_we),
            .cfg_div (sif.cfg_div),
            .tick    (w_tick[i]),
            .phase   (w_phase[i]),
            .wrap    (w_wrap[i])
        );
    end

    // Only channel 0 terminates a single step; other wraps have no consumer.
    assign w_unused_wrap = ^w_wrap;

    always_comb begin
        state_d    = state_q;
        step_ack_d = 1'b0;
        case (state_q)
            STOPPED: begin
                if (sif.run_en) begin
                    state_d = RUNNING;
                end else if (sif.step_req) begin
                    state_d = STEPPING;
                end
            end
            RUNNING: begin
                if (!sif.run_en) begin
                    state_d = STOPPED;
                end
            end
            STEPPING: begin
                if (w_wrap[0]) begin
                    state_d    = STOPPED;
                    step_ack_d = 1'b1;
                end
            end
            default: state_d = STOPPED;
        endcase
        busy_d = (state_d != STOPPED);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= STOPPED;
            step_ack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_ack_q <= step_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign sif.tick     = w_tick;
    assign sif.phase    = w_phase;
    assign sif.step_ack = step_ack_q;
    assign sif.busy     = busy_q;

endmodule

`default_nettype wire

// File: doc/clk_en_sched.md
# clk_en_sched

Clock-enable scheduler that replaces free-running divided clocks with single-cycle enable strobes and matching square-wave phases, all in the `CLK` domain. It runs `N_CH` independently programmable divider channels under one run/stop/single-step controller. Divisor changes are applied glitch-free at channel wrap. The block sits beside the top-level clock source and feeds display-refresh, sampling and slow-step logic.

## Interface
- `N_CH`, 2: number of divider channels (1..8).
- `CNT_W`, 19: divisor/counter width.
- `RST_DIV`, 2**(CNT_W-1)-1: reset divisor for every channel.
- `CLK` in 1: sole clock, rising edge.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `run_en` in 1: level; 1 = free-run, 0 = stop.
- `step_req` in 1: single-cycle pulse requesting one channel-0 period while stopped.
- `step_ack` out 1: one-cycle pulse when a step completes.
- `cfg_we` in 1: divisor write strobe.
- `cfg_ch` in $clog2(N_CH) (min 1): target channel. Values >= `N_CH` are ignored.
- `cfg_div` in CNT_W: new divisor D. Tick period is D+1 cycles.
- `tick` out N_CH: per-channel one-cycle enable strobe.
- `phase` out N_CH: per-channel square wave that toggles on each tick.
- `busy` out 1: high in RUNNING or STEPPING.

## Operation
- **Reset values** (all registers): state = STOPPED; cnt[i] = 0; div[i] = RST_DIV; pend_vld[i] = 0; tick = 0; phase = 0; step_ack = 0; busy = 0.
- **FSM states:** STOPPED, RUNNING, STEPPING.
  - STOPPED -> RUNNING when `run_en` = 1. `run_en` has priority over `step_req` in the same cycle.
  - STOPPED -> STEPPING when `run_en` = 0 and `step_req` = 1.
  - RUNNING -> STOPPED when `run_en` = 0.
  - STEPPING -> STOPPED on the edge that sets tick[0]. The same edge sets `step_ack` = 1.
  - In STEPPING, `run_en` and `step_req` are ignored until completion.
  - `step_req` in RUNNING is dropped: no ack.
- **Advance** = (state is RUNNING or STEPPING). Counters hold when not advancing.
- **Per channel, on an advancing edge:**
  - If cnt == div: cnt <= 0, tick <= 1, phase <= ~phase, and the divisor is reloaded.
  - Otherwise: cnt <= cnt + 1, tick <= 0.
- **Reload at wrap:** if pend_vld, div <= pend and pend_vld <= 0.
- Non-advancing edges: tick <= 0.
- **Divisor writes:**
  - In STOPPED: the write loads div and clears cnt immediately; pend is untouched.
  - Otherwise: the write stores into pend and sets pend_vld. A later write overwrites pend (last write wins).
  - A write on the same edge as that channel's wrap: the written value is the one loaded at that wrap.
- **D = 0:** tick is high on every advancing cycle; phase toggles every cycle.
- Counter is unsigned CNT_W bits. cnt never exceeds div, so no overflow path exists.
- **Mid-operation events:**
  - Reset asserted mid-operation: immediate return to reset values, including pend_vld.
  - Dropping `run_en` mid-period: cnt values are frozen and resume from there on restart.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- From the edge entering RUNNING, with cnt = 0 and divisor D: the first advance is on the next edge, and tick rises on the (D+1)-th advancing edge. Period is D+1; phase period is 2(D+1).
- `step_ack` is concurrent with tick[0] and lasts exactly one cycle. `busy` drops on the same edge.
- Step latency is (div[0] − cnt[0] + 1) cycles after the STEPPING entry edge.

## Structure
- Package `clk_en_pkg`:
  - state enum `sched_state_t` {STOPPED, RUNNING, STEPPING};
  - default `CNT_W`;
  - function returning the `RST_DIV` default.
- Sub-module `clk_en_chan`: holds one channel's cnt/div/pend/pend_vld/tick/phase logic.
  - Inputs: `advance`, `stopped`, `cfg_we` qualified by channel match.
  - Instantiated N_CH times by generate.
- Top level holds only the FSM and `step_ack`/`busy`.

## Test plan
- **Reset/default:** release `RST_N`, hold `run_en` = 1 with CNT_W = 19 -> tick[0] period 262144 cycles, phase[0] period 524288, first tick 262144 edges after RUNNING entry.
- **Small divisors:** in STOPPED write ch0 D = 3 and ch1 D = 0, then run -> tick[0] every 4 cycles, tick[1] every cycle, phase[1] toggling each cycle.
- **Live reprogram:** running with ch0 D = 5 and cnt = 2, write D = 1 -> remaining ticks at D = 5 until the wrap, then period 2. A write landing on the wrap edge takes effect at that wrap.
- **Single step:** stopped, ch0 D = 4, cnt = 0, pulse `step_req` -> exactly one tick[0] and a coincident `step_ack` 5 cycles later, then counters frozen. A second `step_req` during STEPPING produces no extra ack.
- **Priority/ignore:** `run_en` and `step_req` asserted together in STOPPED -> RUNNING with no ack. `step_req` while RUNNING -> no ack.
- **Async reset mid-run:** drop `RST_N` between clock edges with pend_vld = 1 -> outputs reach reset values without waiting for a clock edge, and the pending divisor is discarded after release.
